// File: rtl/lsu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_arbiter
// Brief    : Two-master (core LSU / debug-DMA) arbiter for the data bus.
// Revision : 1.0
// ============================================================================
module lsu_bus_arbiter #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_strb_i,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_strb_i,
    input  logic        m1_lock_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m_rdata_o,
    output logic        core_stall_o,
    output logic        s_en_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_strb_o,
    input  logic [31:0] s_rdata_i
);

    localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);

    logic       r_last_gnt;
    logic [7:0] r_lock_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_any;
    logic       w_we;

    // Lock only overrides round-robin when m1 already owns the bus.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_ni) begin
            if (m0_req_i && m1_req_i) begin
                if (m1_lock_i && r_last_gnt)
                    w_gnt1 = (r_lock_cnt < c_lock_max);
                else
                    w_gnt1 = ~r_last_gnt;
                w_gnt0 = ~w_gnt1;
            end else begin
                w_gnt0 = m0_req_i;
                w_gnt1 = m1_req_i;
            end
        end
    end

    assign w_any = w_gnt0 | w_gnt1;
    assign w_we  = w_gnt1 ? m1_we_i : (w_gnt0 & m0_we_i);

    assign m0_gnt_o     = w_gnt0;
    assign m1_gnt_o     = w_gnt1;
    assign core_stall_o = rst_ni & m0_req_i & ~w_gnt0;

    assign s_en_o    = w_any;
    assign s_we_o    = w_we;
    assign s_addr_o  = w_gnt1 ? m1_addr_i  : (w_gnt0 ? m0_addr_i  : 32'd0);
    assign s_wdata_o = w_gnt1 ? m1_wdata_i : (w_gnt0 ? m0_wdata_i : 32'd0);
    assign s_strb_o  = !w_we ? 4'd0 : (w_gnt1 ? m1_strb_i : m0_strb_i);

    assign m0_rvalid_o = rst_ni & r_rd_pend & ~r_rd_owner;
    assign m1_rvalid_o = rst_ni & r_rd_pend &  r_rd_owner;
    assign m_rdata_o   = (rst_ni && r_rd_pend) ? s_rdata_i : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_gnt <= 1'b1;
            r_lock_cnt <= 8'd0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            if (w_any)
                r_last_gnt <= w_gnt1;
            r_rd_pend  <= w_any & ~w_we;
            r_rd_owner <= w_gnt1;
            if (w_gnt0 || !m0_req_i || !m1_req_i || !m1_lock_i)
                r_lock_cnt <= 8'd0;
            else if (w_gnt1 && (r_lock_cnt < c_lock_max))
                r_lock_cnt <= r_lock_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_arbiter
// Brief    : Directed + random stimulus against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_lsu_bus_arbiter;

    localparam int c_lock_max = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i, m1_lock_i;
    logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i, s_rdata_i;
    logic [3:0]  m0_strb_i, m1_strb_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, core_stall_o;
    logic        s_en_o, s_we_o;
    logic [31:0] m_rdata_o, s_addr_o, s_wdata_o;
    logic [3:0]  s_strb_o;

    lsu_bus_arbiter #(.LOCK_MAX(c_lock_max)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_strb_i(m0_strb_i),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_strb_i(m1_strb_i), .m1_lock_i(m1_lock_i),
        .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m_rdata_o(m_rdata_o), .core_stall_o(core_stall_o),
        .s_en_o(s_en_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_strb_o(s_strb_o), .s_rdata_i(s_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owned the bus last, how long m1 has held it
    // under lock, and which master (if any) is owed read data.
    int mdl_last;
    int mdl_streak;
    int mdl_owed;   // -1 none, else master index

    logic g0_seen, g1_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pick_winner();
        if (!rst_ni) return -1;
        if (m0_req_i && !m1_req_i) return 0;
        if (m1_req_i && !m0_req_i) return 1;
        if (!m0_req_i && !m1_req_i) return -1;
        if (m1_lock_i && mdl_last == 1)
            return (mdl_streak < c_lock_max) ? 1 : 0;
        return 1 - mdl_last;
    endfunction

    // Inputs are already applied; check mid-cycle, then advance the model at the edge.
    task automatic step();
        int          w;
        logic        wr;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_strb;
        s_rdata_i = $urandom;
        #4;
        w  = pick_winner();
        wr = (w == 1) ? m1_we_i : ((w == 0) ? m0_we_i : 1'b0);
        exp_addr  = (w == 1) ? m1_addr_i  : ((w == 0) ? m0_addr_i  : 32'd0);
        exp_wdata = (w == 1) ? m1_wdata_i : ((w == 0) ? m0_wdata_i : 32'd0);
        exp_strb  = !wr ? 4'd0 : ((w == 1) ? m1_strb_i : m0_strb_i);
        check_eq("m0_gnt",  32'(m0_gnt_o), 32'(w == 0));
        check_eq("m1_gnt",  32'(m1_gnt_o), 32'(w == 1));
        check_eq("s_en",    32'(s_en_o),   32'(w >= 0));
        check_eq("s_we",    32'(s_we_o),   32'(wr));
        check_eq("s_addr",  s_addr_o,  exp_addr);
        check_eq("s_wdata", s_wdata_o, exp_wdata);
        check_eq("s_strb",  32'(s_strb_o), 32'(exp_strb));
        check_eq("stall",   32'(core_stall_o), 32'(rst_ni && m0_req_i && w != 0));
        check_eq("m0_rvalid", 32'(m0_rvalid_o), 32'(rst_ni && mdl_owed == 0));
        check_eq("m1_rvalid", 32'(m1_rvalid_o), 32'(rst_ni && mdl_owed == 1));
        check_eq("m_rdata", m_rdata_o, (rst_ni && mdl_owed >= 0) ? s_rdata_i : 32'd0);
        g0_seen = m0_gnt_o;
        g1_seen = m1_gnt_o;
        @(posedge clk_i);
        if (!rst_ni) begin
            mdl_last = 1; mdl_streak = 0; mdl_owed = -1;
        end else begin
            mdl_owed = (w >= 0 && !wr) ? w : -1;
            if (w >= 0) mdl_last = w;
            if (w == 0 || !m0_req_i || !m1_req_i || !m1_lock_i) mdl_streak = 0;
            else if (w == 1 && mdl_streak < c_lock_max) mdl_streak++;
        end
        #1;
    endtask

    task automatic idle();
        m0_req_i = 0; m1_req_i = 0; m1_lock_i = 0; m0_we_i = 0; m1_we_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0; m0_req_i = 1; m1_req_i = 1;
        step();
        idle();
        step();
        rst_ni = 1;
    endtask

    initial begin
        int run;
        logic done;
        rst_ni = 0; idle(); s_rdata_i = 0;
        m0_addr_i = 0; m0_wdata_i = 0; m0_strb_i = 0;
        m1_addr_i = 0; m1_wdata_i = 0; m1_strb_i = 0;
        mdl_last = 1; mdl_streak = 0; mdl_owed = -1;
        g0_seen = 0; g1_seen = 0;
        @(posedge clk_i); #1;
        do_reset();

        // Lone m0 read, then data one cycle later
        m0_req_i = 1; m0_we_i = 0; m0_addr_i = 32'h10; step();
        idle(); step();

        // Continuous tie, no lock: strict alternation starting with m0
        do_reset();
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h20; m1_addr_i = 32'h24;
        for (int i = 0; i < 6; i++) step();
        idle(); step();

        // Lock run: LOCK_MAX m1 grants, one m0 grant, then m1 again
        do_reset();
        m0_req_i = 1; m1_req_i = 1; m1_lock_i = 1;
        run = 0; done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (!done && g1_seen) run++;
            if (g0_seen) done = 1;
        end
        check_eq("lock_run_len", 32'(run), 32'(c_lock_max));
        idle(); step();

        // m1 partial write
        m1_req_i = 1; m1_we_i = 1; m1_addr_i = 32'h7020;
        m1_wdata_i = 32'hDEADBEEF; m1_strb_i = 4'b0011; step();
        idle(); step();

        // Alternating back-to-back reads
        m0_req_i = 1; m0_addr_i = 32'h100; step();
        idle(); m1_req_i = 1; m1_addr_i = 32'h104; step();
        idle(); m0_req_i = 1; m0_addr_i = 32'h108; step();
        idle(); step();

        // Reset right after an m1 read: data must be dropped
        m1_req_i = 1; m1_addr_i = 32'h200; step();
        idle(); rst_ni = 0; step();
        rst_ni = 1; m0_req_i = 1; m1_req_i = 1; step();
        idle(); step();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_ni     = ($urandom_range(0, 29) != 0);
            m0_req_i   = $urandom_range(0, 3) != 0;
            m1_req_i   = $urandom_range(0, 3) != 0;
            m1_lock_i  = $urandom_range(0, 2) != 0;
            m0_we_i    = $urandom;
            m1_we_i    = $urandom;
            m0_addr_i  = $urandom; m1_addr_i  = $urandom;
            m0_wdata_i = $urandom; m1_wdata_i = $urandom;
            m0_strb_i  = 4'($urandom); m1_strb_i = 4'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_bus_arbiter.md
# lsu_bus_arbiter

Two-master arbiter for the data-memory/IO bus behind the LSU. Master 0 is the single-cycle core's load/store path; master 1 is a debug/DMA port that peeks and pokes data memory and IO registers while the core runs. The arbiter grants one master per cycle and forwards its command to the shared slave. It returns one-cycle-latency read data to the owner and tells the core when to stall.

## Interface
Parameters:
- LOCK_MAX, 8: maximum consecutive grants master 1 may hold under lock while master 0 waits (1..255).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- m0_req_i / m1_req_i  in  1  bus request, held until granted
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  32  byte address
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_strb_i / m1_strb_i  in  4  byte strobes, writes only
- m1_lock_i  in  1  master 1 requests back-to-back ownership
- m0_gnt_o / m1_gnt_o  out  1  command accepted this cycle
- m0_rvalid_o / m1_rvalid_o  out  1  read data valid
- m_rdata_o  out  32  read data, shared; qualified by rvalid
- core_stall_o  out  1  m0_req_i & ~m0_gnt_o; freezes PC and register-file write
- s_en_o  out  1  slave command strobe
- s_we_o  out  1  slave write enable
- s_addr_o  out  32  slave address
- s_wdata_o  out  32  slave write data
- s_strb_o  out  4  slave byte strobes, forced 0 on reads
- s_rdata_i  in  32  slave read data, valid exactly 1 cycle after a read command

## Operation
- Registered state:
  - last_gnt (1 bit, 0 = m0 last)
  - lock_cnt (8 bits)
  - rd_pend (1 bit)
  - rd_owner (1 bit)
- Arbitration is combinational from the req inputs and the registered state. At most one gnt per cycle.
- Only one requester: it is granted.
- Both request, no lock: round-robin. The master not equal to last_gnt wins.
- Both request, m1_lock_i = 1 and last_gnt = 1: m1 wins while lock_cnt < LOCK_MAX. When lock_cnt = LOCK_MAX, m0 wins once and lock_cnt clears.
- lock_cnt update:
  - increments on each m1 grant while m0_req_i = 1 and m1_lock_i = 1;
  - clears on any m0 grant, on a cycle with m0_req_i = 0, or when m1_lock_i = 0;
  - saturates at LOCK_MAX and never wraps.
- On a grant, the slave outputs mirror the winner's command, s_en_o = 1 in the same cycle, and last_gnt updates at the next edge.
- No grant: s_en_o = 0. s_addr/s_wdata/s_we/s_strb are held at 0.
- A read grant sets rd_pend = 1 and rd_owner = winner at the next edge. In the following cycle, rvalid of rd_owner = 1 and m_rdata_o = s_rdata_i.
- Write grants produce no rvalid. A write is complete at the grant edge.
- Back-to-back reads from alternating masters are allowed every cycle. rd_pend/rd_owner reload each cycle and there is no bubble.

## Timing
- Reset (rst_ni = 0 at a rising edge): last_gnt = 1 (m0 wins the first tie), lock_cnt = 0, rd_pend = 0.
- While rst_ni = 0, gnts, s_en_o, rvalids and core_stall_o are forced 0 combinationally. m_rdata_o = 0.
- Grant latency: 0 cycles (same cycle as req when the master wins).
- Read data latency: 1 cycle after grant.
- Worst-case m0 wait: 1 cycle without lock; LOCK_MAX cycles with lock.
- Reset mid-read: a pending rvalid is dropped and never asserted after reset.
- Req deasserted before grant: allowed. No state changes.
- m1_lock_i with m1_req_i = 0: ignored; lock_cnt clears.
- Simultaneous m0 write and m1 read to the same address: only one is granted per cycle, so there is no hazard inside the arbiter.

## Test plan
- Reset, then m0 read at 0x0000_0010 alone -> m0_gnt_o = 1 same cycle, s_addr_o = 0x10, s_we_o = 0; next cycle m0_rvalid_o = 1, m_rdata_o = s_rdata_i; core_stall_o = 0 throughout.
- Both masters request continuously, no lock, from reset -> grant sequence m0, m1, m0, m1…; core_stall_o = 1 on every m1 cycle.
- m1_lock_i = 1, both request, LOCK_MAX = 8, m1 granted first -> eight m1 grants, then one m0 grant, lock_cnt = 0, then m1 resumes.
- m1 write 0xDEADBEEF, strb 4'b0011, to 0x7020 -> s_en_o = 1, s_we_o = 1, s_strb_o = 4'b0011, s_wdata_o = 0xDEADBEEF; no rvalid next cycle.
- Alternating reads m0 @0x100, m1 @0x104, m0 @0x108 on consecutive cycles -> rvalid toggles m0, m1, m0 one cycle later with matching data; no gaps.
- m1 read granted, rst_ni = 0 on the next edge -> m1_rvalid_o never asserts; after release, last_gnt = 1 and an m0/m1 tie goes to m0.
